// File: rtl/ofdm_cp_strip.sv
// ofdm_cp_strip: strips the cyclic prefix of each OFDM symbol and frames the payload as an Avalon-ST packet for the FFT.
// Latency: an accepted payload sample reaches out_valid one cycle later when the output buffer is empty.
// Backpressure: the input never stalls; out_ready stalls are absorbed by the FIFO, and a full FIFO drops the sample and sets ovf.
// Build option: define OFDM_CP_SYM_CNT_EN to add the sym_count output and sym_count_clr input.

// ofdm_cp_fifo: generic synchronous FIFO with the head entry presented combinationally from storage.
// Latency: a write into an empty FIFO shows rd_vld on the next cycle.
// Backpressure: wr_rdy drops when full unless the same cycle pops; rd_dat holds while rd_vld & !rd_rdy.
module ofdm_cp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign rd_vld  = (count != '0);
  assign rd_dat  = mem[rd_ptr];
  assign do_pop  = rd_vld & rd_rdy;
  // a pop in the same cycle frees the slot, so a full FIFO can still take a write
  assign wr_rdy  = (count != FULL_CNT) | do_pop;
  assign do_push = wr_vld & wr_rdy;

  // storage write; contents are only observed through rd_vld so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  // pointers and occupancy; reset flushes the FIFO immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ofdm_cp_strip #(
  parameter int DATA_W     = 12,
  parameter int PTS_W      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              sym_start,
  input  logic [PTS_W-1:0]  fft_pts,
  input  logic [PTS_W-1:0]  cp_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [1:0]        out_error,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [PTS_W-1:0]  out_fftpts,
  output logic              ovf,
  output logic              sync_err
`ifdef OFDM_CP_SYM_CNT_EN
  ,
  output logic [15:0]       sym_count,
  input  logic              sym_count_clr
`endif
);
  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic              sop;
    logic              eop;
    logic              err;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SKIP_CP, PAYLOAD} state_t;

  state_t         state, state_nxt;
  logic [PTS_W:0] cnt, cnt_nxt, cnt_inc;
  logic [PTS_W-1:0] fft_q, cp_q;
  logic [PTS_W:0] fft_last, cp_ext;
  logic           latch_en, sync_hit, err_sym, drop;
  logic           wr_vld, wr_rdy, rd_vld;
  entry_t         wr_dat, rd_dat;
  logic [PTS_W-1:0] fftpts_r;

  assign cnt_inc  = cnt + 1'b1;
  assign cp_ext   = {1'b0, cp_q};
  assign fft_last = {1'b0, fft_q} - 1'b1;

  // framing: skip the CP, tag sop/eop on payload samples, flag ignored symbol starts
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    latch_en   = 1'b0;
    sync_hit   = 1'b0;
    wr_vld     = 1'b0;
    wr_dat.re  = in_real;
    wr_dat.im  = in_imag;
    wr_dat.sop = 1'b0;
    wr_dat.eop = 1'b0;
    wr_dat.err = err_sym;
    case (state)
      IDLE: begin
        if (in_valid && sym_start) begin
          latch_en   = 1'b1;
          wr_dat.err = 1'b0;
          if (cp_len == '0) begin
            // no prefix: this sample opens the payload
            state_nxt  = PAYLOAD;
            cnt_nxt    = {{PTS_W{1'b0}}, 1'b1};
            wr_vld     = 1'b1;
            wr_dat.sop = 1'b1;
          end else if (cp_len == PTS_W'(1)) begin
            // this sample is the whole prefix
            state_nxt = PAYLOAD;
            cnt_nxt   = '0;
          end else begin
            state_nxt = SKIP_CP;
            cnt_nxt   = {{PTS_W{1'b0}}, 1'b1};
          end
        end
      end
      SKIP_CP: begin
        if (in_valid) begin
          sync_hit = sym_start;
          if (cnt_inc == cp_ext) begin
            state_nxt = PAYLOAD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      PAYLOAD: begin
        if (in_valid) begin
          sync_hit   = sym_start;
          wr_vld     = 1'b1;
          wr_dat.sop = (cnt == '0);
          wr_dat.eop = (cnt == fft_last);
          if (cnt == fft_last) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a payload sample that finds no room is lost; cnt still advances in the FSM
  assign drop = wr_vld & ~wr_rdy;

  // state and sample counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // symbol geometry captured at the accepted symbol start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fft_q <= '0;
      cp_q  <= '0;
    end else if (latch_en) begin
      fft_q <= fft_pts;
      cp_q  <= cp_len;
    end
  end

  // status flags: sticky overflow, per-symbol error marking, ignored-start pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf      <= 1'b0;
      err_sym  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      ovf      <= ovf | drop;
      sync_err <= sync_hit;
      if (drop)          err_sym <= 1'b1;
      else if (latch_en) err_sym <= 1'b0;
    end
  end

  ofdm_cp_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (wr_vld),
    .wr_rdy (wr_rdy),
    .wr_dat (wr_dat),
    .rd_vld (rd_vld),
    .rd_rdy (out_ready),
    .rd_dat (rd_dat)
  );

  assign out_valid  = rd_vld;
  assign out_sop    = rd_vld & rd_dat.sop;
  assign out_eop    = rd_vld & rd_dat.eop;
  assign out_error  = {1'b0, rd_vld & rd_dat.err};
  assign out_real   = rd_vld ? rd_dat.re : '0;
  assign out_imag   = rd_vld ? rd_dat.im : '0;
  // point count follows the symbol geometry as its sop is presented, then holds
  assign out_fftpts = out_sop ? fft_q : fftpts_r;

  // hold register behind out_fftpts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fftpts_r <= '0;
    else       fftpts_r <= out_fftpts;
  end

`ifdef OFDM_CP_SYM_CNT_EN
  // count completed symbols leaving the block; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              sym_count <= '0;
    else if (sym_count_clr)                 sym_count <= '0;
    else if (rd_vld & out_ready & rd_dat.eop) sym_count <= sym_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_ofdm_cp_strip.sv
// tb_ofdm_cp_strip: random and directed symbol streams checked against a queue-based reference model.
// Latency: outputs compared every cycle on the falling edge.
// Backpressure: out_ready is driven randomly or held low to exercise stalls and overflow.
module tb_ofdm_cp_strip;
  localparam int DW    = 12;
  localparam int PW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_real = '0;
  logic [DW-1:0] in_imag = '0;
  logic          sym_start = 1'b0;
  logic [PW-1:0] fft_pts = '0;
  logic [PW-1:0] cp_len = '0;
  logic          out_ready = 1'b0;
  logic          out_valid, out_sop, out_eop, ovf, sync_err;
  logic [1:0]    out_error;
  logic [DW-1:0] out_real, out_imag;
  logic [PW-1:0] out_fftpts;
`ifdef OFDM_CP_SYM_CNT_EN
  logic [15:0]   sym_count;
  logic          sym_count_clr = 1'b0;
`endif

  ofdm_cp_strip #(.DATA_W(DW), .PTS_W(PW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .sym_start  (sym_start),
    .fft_pts    (fft_pts),
    .cp_len     (cp_len),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_error  (out_error),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .out_fftpts (out_fftpts),
    .ovf        (ovf),
`ifdef OFDM_CP_SYM_CNT_EN
    .sym_count     (sym_count),
    .sym_count_clr (sym_count_clr),
`endif
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    bit            sop;
    bit            eop;
    bit            err;
  } ent_t;

  // reference model: a symbol is cp prefix samples followed by fft payload samples
  ent_t mq[$];
  bit   m_in_sym, m_err_sym, m_ovf, m_sync;
  int   m_pos, m_cp, m_fft, m_fft_latched, m_hold, m_symcnt;

  int checks = 0;
  int errors = 0;
  int dut_pops, dut_err_pops, n_sync;
  int sop_val, eop_val;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_in_sym = 0; m_err_sym = 0; m_ovf = 0; m_sync = 0;
    m_pos = 0; m_cp = 0; m_fft = 0; m_fft_latched = 0; m_hold = 0; m_symcnt = 0;
  endtask

  task automatic check_outputs();
    bit have;
    int exp_fpts;
    have = (mq.size() != 0);
    chk("out_valid", out_valid, have);
    if (have) begin
      chk("out_real", out_real, mq[0].re);
      chk("out_imag", out_imag, mq[0].im);
      chk("out_sop", out_sop, mq[0].sop);
      chk("out_eop", out_eop, mq[0].eop);
      chk("out_error", out_error, mq[0].err ? 1 : 0);
    end
    exp_fpts = (have && mq[0].sop) ? m_fft_latched : m_hold;
    chk("out_fftpts", out_fftpts, exp_fpts);
    chk("ovf", ovf, m_ovf);
    chk("sync_err", sync_err, m_sync);
`ifdef OFDM_CP_SYM_CNT_EN
    chk("sym_count", sym_count, m_symcnt & 16'hFFFF);
`endif
    if (sync_err === 1'b1) n_sync++;
  endtask

  // advance the model across the coming rising edge, using the inputs now driven
  task automatic model_step();
    bit pop, full, push, sync;
    ent_t e;
    push = 0; sync = 0;
    e.re = in_real; e.im = in_imag; e.sop = 0; e.eop = 0; e.err = 0;
    pop  = out_ready && (mq.size() != 0);
    full = (mq.size() == DEPTH);
    if (mq.size() != 0 && mq[0].sop) m_hold = m_fft_latched;
    if (in_valid) begin
      if (m_in_sym) begin
        if (sym_start) sync = 1;
      end else if (sym_start) begin
        m_in_sym = 1; m_pos = 0; m_cp = cp_len; m_fft = fft_pts;
        m_fft_latched = fft_pts; m_err_sym = 0;
      end
      if (m_in_sym) begin
        if (m_pos >= m_cp) begin
          e.sop = (m_pos == m_cp);
          e.eop = (m_pos == m_cp + m_fft - 1);
          e.err = m_err_sym;
          push  = 1;
          if (e.eop) m_in_sym = 0;
        end
        m_pos++;
      end
    end
    if (pop) begin
      if (mq[0].eop) m_symcnt++;
      void'(mq.pop_front());
    end
    if (push) begin
      if (full && !pop) begin
        m_ovf = 1; m_err_sym = 1;
      end else begin
        mq.push_back(e);
      end
    end
    m_sync = sync;
    // observed handshakes, for the directed summaries
    if (out_valid && out_ready) begin
      dut_pops++;
      if (out_error != 2'b00) dut_err_pops++;
      if (out_sop) sop_val = out_real;
      if (out_eop) eop_val = out_real;
    end
  endtask

  task automatic cyc(input bit v, input bit ss, input logic [DW-1:0] re, input logic [DW-1:0] im, input bit rdy);
    @(negedge clk);
    check_outputs();
    in_valid = v; sym_start = ss; in_real = re; in_imag = im; out_ready = rdy;
    model_step();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic clear_obs();
    dut_pops = 0; dut_err_pops = 0; n_sync = 0; sop_val = -1; eop_val = -1;
  endtask

  initial begin
    model_reset();
    clear_obs();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_out_fftpts", out_fftpts, 0);
    chk("rst_out_error", out_error, 0);
    reset = 1'b0;

    // 64-point symbol with 16-sample prefix, values equal to sample index
    fft_pts = 8'd64; cp_len = 8'd16; clear_obs();
    for (int i = 0; i < 80; i++) cyc(1'b1, i == 0, DW'(i), DW'(i + 7), 1'b1);
    drain(4);
    chk("t1_pops", dut_pops, 64);
    chk("t1_sop_val", sop_val, 16);
    chk("t1_eop_val", eop_val, 79);
    chk("t1_fftpts", out_fftpts, 64);

    // zero-length prefix, back-to-back 8-point symbols
    fft_pts = 8'd8; cp_len = 8'd0; clear_obs();
    for (int i = 0; i < 24; i++) cyc(1'b1, (i % 8) == 0, DW'(i), DW'(100 + i), 1'b1);
    drain(4);
    chk("t2_pops", dut_pops, 24);
    chk("t2_first_sop_last", sop_val, 16);

    // stray symbol start at payload index 5
    fft_pts = 8'd64; cp_len = 8'd16; clear_obs();
    for (int i = 0; i < 80; i++) cyc(1'b1, i == 0 || i == 21, DW'(i), DW'(3 * i), 1'b1);
    drain(4);
    chk("t5_sync_pulses", n_sync, 1);
    chk("t5_pops", dut_pops, 64);

    // 10-cycle stall mid-payload on a 128-point symbol
    fft_pts = 8'd128; cp_len = 8'd32; clear_obs();
    for (int i = 0; i < 160; i++) cyc(1'b1, i == 0, DW'($urandom), DW'($urandom), !(i >= 60 && i < 70));
    drain(20);
    chk("t3_ovf", ovf, 0);
    chk("t3_pops", dut_pops, 128);

    // random symbols, gaps, stray starts and stalls
    for (int c = 0; c < 4000; c++) begin
      bit v, ss;
      int r;
      v  = ($urandom_range(0, 9) < 8);
      ss = 0;
      if (!m_in_sym) begin
        if ($urandom_range(0, 3) == 0) begin
          ss = 1;
          fft_pts = PW'(8 << $urandom_range(0, 4));
          r = $urandom_range(0, 3);
          case (r)
            0: cp_len = '0;
            1: cp_len = PW'(1);
            2: cp_len = fft_pts;
            default: cp_len = PW'($urandom_range(0, int'(fft_pts)));
          endcase
        end
      end else if ($urandom_range(0, 59) == 0) begin
        ss = 1;
      end
      cyc(v, ss, DW'($urandom), DW'($urandom), $urandom_range(0, 9) != 0);
    end
    for (int k = 0; k < 300 && m_in_sym; k++) cyc(1'b1, 1'b0, DW'($urandom), DW'($urandom), 1'b1);
    drain(20);

    // overflow: ready low for the first 40 payload samples
    fft_pts = 8'd128; cp_len = 8'd0; clear_obs();
    for (int i = 0; i < 128; i++) cyc(1'b1, i == 0, DW'($urandom), DW'($urandom), i >= 40);
    drain(20);
    chk("t4_ovf", ovf, 1);
    chk("t4_pops", dut_pops, 16 + 88);
    chk("t4_err_pops", dut_err_pops, 88);

    // reset with 7 entries buffered
    fft_pts = 8'd16; cp_len = 8'd2;
    for (int i = 0; i < 9; i++) cyc(1'b1, i == 0, DW'($urandom), DW'($urandom), 1'b0);
    @(negedge clk);
    check_outputs();
    reset = 1'b1; in_valid = 1'b0; sym_start = 1'b0; out_ready = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_out_sop", out_sop, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    fft_pts = 8'd8; cp_len = 8'd3; clear_obs();
    for (int i = 0; i < 11; i++) cyc(1'b1, i == 0, DW'(i), DW'(i), 1'b1);
    drain(4);
    chk("post_rst_pops", dut_pops, 8);
    chk("post_rst_sop_val", sop_val, 3);
    chk("post_rst_eop_val", eop_val, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
